mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow 128-bit memory between an instruction-side and
// a data-side cache requester. A three-state FSM owns the memory for one
// transaction at a time, latches the winning request on entry, holds it until
// mem_ready, then drops back to IDLE for at least one cycle.
module mem_arbiter #(
    parameter int ARB_MODE = 0,   // 0: round-robin on ties, 1: D-side always wins ties
    parameter int CNT_W    = 16   // width of the completed-transaction counters
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              read_I,
    input  logic              write_I,
    input  logic [31:4]       addr_I,
    input  logic [127:0]      wdata_I,
    output logic [127:0]      rdata_I,
    output logic              ready_I,

    input  logic              read_D,
    input  logic              write_D,
    input  logic [31:4]       addr_D,
    input  logic [127:0]      wdata_D,
    output logic [127:0]      rdata_D,
    output logic              ready_D,

    output logic              mem_read,
    output logic              mem_write,
    output logic [31:4]       mem_addr,
    output logic [127:0]      mem_wdata,
    input  logic [127:0]      mem_rdata,
    input  logic              mem_ready,

    output logic              grant_I,
    output logic              grant_D,
    output logic [CNT_W-1:0]  cnt_I,
    output logic [CNT_W-1:0]  cnt_D
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    // Encoding of the last-served port used for round-robin tie breaking.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t state_r;
    logic   last_grant_r;
    logic   pend_i_s;
    logic   pend_d_s;
    logic   pick_d_s;

    // Counters stick at all-ones so a long-running system never reports a
    // misleadingly small transaction count after wrap-around.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Decide which pending port would win if the FSM is idle this cycle.
    always_comb begin
        pend_i_s = read_I | write_I;
        pend_d_s = read_D | write_D;
        pick_d_s = 1'b0;
        if (pend_d_s && !pend_i_s) begin
            pick_d_s = 1'b1;
        end else if (pend_d_s && pend_i_s) begin
            if (ARB_MODE == 32'sd1) begin
                pick_d_s = 1'b1;
            end else begin
                // Serve whichever port did not get the previous transaction.
                pick_d_s = (last_grant_r == GRANT_I);
            end
        end else begin
            pick_d_s = 1'b0;
        end
    end

    // Arbitration FSM; memory command, address, data and counters are all
    // registered here so they stay frozen for the whole BUSY period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= GRANT_I;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= 28'd0;
            mem_wdata    <= 128'd0;
            cnt_I        <= {CNT_W{1'b0}};
            cnt_D        <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    // mem_ready seen here is stray and deliberately ignored.
                    if (pend_i_s || pend_d_s) begin
                        if (pick_d_s) begin
                            state_r   <= BUSY_D;
                            mem_addr  <= addr_D;
                            mem_wdata <= wdata_D;
                            mem_write <= write_D;
                            mem_read  <= read_D & ~write_D;
                        end else begin
                            state_r   <= BUSY_I;
                            mem_addr  <= addr_I;
                            mem_wdata <= wdata_I;
                            mem_write <= write_I;
                            mem_read  <= read_I & ~write_I;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        state_r      <= IDLE;
                        mem_read     <= 1'b0;
                        mem_write    <= 1'b0;
                        last_grant_r <= GRANT_I;
                        cnt_I        <= sat_inc(cnt_I);
                    end else begin
                        state_r <= BUSY_I;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        state_r      <= IDLE;
                        mem_read     <= 1'b0;
                        mem_write    <= 1'b0;
                        last_grant_r <= GRANT_D;
                        cnt_D        <= sat_inc(cnt_D);
                    end else begin
                        state_r <= BUSY_D;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

    // Ready is combinational so the requester sees the response in the same
    // cycle the memory delivers it; read data is a straight pass-through.
    assign ready_I = mem_ready && (state_r == BUSY_I);
    assign ready_D = mem_ready && (state_r == BUSY_D);
    assign rdata_I = mem_rdata;
    assign rdata_D = mem_rdata;
    assign grant_I = (state_r == BUSY_I);
    assign grant_D = (state_r == BUSY_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: randomized round-robin traffic against a
// transaction-level scoreboard, plus a directed fixed-priority instance.
module tb_mem_arbiter;

    localparam int CW    = 3;
    localparam int CMAX  = 7;
    localparam int NONE  = 0;
    localparam int OWN_I = 1;
    localparam int OWN_D = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Round-robin DUT signals
    logic          read_I, write_I, ready_I, read_D, write_D, ready_D;
    logic [27:0]   addr_I, addr_D, mem_addr;
    logic [127:0]  wdata_I, wdata_D, rdata_I, rdata_D, mem_wdata, mem_rdata;
    logic          mem_read, mem_write, mem_ready, grant_I, grant_D;
    logic [CW-1:0] cnt_I, cnt_D;

    // Fixed-priority DUT signals
    logic          f_read_I, f_write_I, f_ready_I, f_read_D, f_write_D, f_ready_D;
    logic [27:0]   f_addr_I, f_addr_D, f_mem_addr;
    logic [127:0]  f_wdata_I, f_wdata_D, f_rdata_I, f_rdata_D, f_mem_wdata, f_mem_rdata;
    logic          f_mem_read, f_mem_write, f_mem_ready, f_grant_I, f_grant_D;
    logic [CW-1:0] f_cnt_I, f_cnt_D;

    mem_arbiter #(.ARB_MODE(0), .CNT_W(CW)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .read_I(read_I), .write_I(write_I), .addr_I(addr_I), .wdata_I(wdata_I),
        .rdata_I(rdata_I), .ready_I(ready_I),
        .read_D(read_D), .write_D(write_D), .addr_D(addr_D), .wdata_D(wdata_D),
        .rdata_D(rdata_D), .ready_D(ready_D),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_I(grant_I), .grant_D(grant_D), .cnt_I(cnt_I), .cnt_D(cnt_D)
    );

    mem_arbiter #(.ARB_MODE(1), .CNT_W(CW)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .read_I(f_read_I), .write_I(f_write_I), .addr_I(f_addr_I), .wdata_I(f_wdata_I),
        .rdata_I(f_rdata_I), .ready_I(f_ready_I),
        .read_D(f_read_D), .write_D(f_write_D), .addr_D(f_addr_D), .wdata_D(f_wdata_D),
        .rdata_D(f_rdata_D), .ready_D(f_ready_D),
        .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata), .mem_ready(f_mem_ready),
        .grant_I(f_grant_I), .grant_D(f_grant_D), .cnt_I(f_cnt_I), .cnt_D(f_cnt_D)
    );

    typedef struct packed {
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic         rd;
        logic         wr;
    } req_t;

    req_t q_i[$];
    req_t q_d[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   fx_done = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int   op;
        op      = int'($urandom_range(0, 2));
        r.rd    = (op != 1);
        r.wr    = (op != 0);
        r.addr  = 28'($urandom());
        r.wdata = rand128();
        return r;
    endfunction

    // ---------------- scoreboard / reference model -----------------------
    int   m_own, m_last, m_ci, m_cd;
    bit   gap, p_pi, p_pd, p_mrdy;
    req_t cur;

    initial forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
            m_own = NONE; m_last = OWN_I; m_ci = 0; m_cd = 0; gap = 1'b1;
            chk("rst_grant_I", 128'(grant_I), 128'(0));
            chk("rst_grant_D", 128'(grant_D), 128'(0));
            chk("rst_ready_I", 128'(ready_I), 128'(0));
            chk("rst_ready_D", 128'(ready_D), 128'(0));
            chk("rst_mem_cmd", 128'({mem_read, mem_write}), 128'(0));
            chk("rst_mem_addr", 128'(mem_addr), 128'(0));
            chk("rst_mem_wdata", mem_wdata, 128'(0));
            chk("rst_cnt_I", 128'(cnt_I), 128'(0));
            chk("rst_cnt_D", 128'(cnt_D), 128'(0));
        end else begin
            // Advance the model by what happened at the last rising edge.
            if (gap) begin
                gap = 1'b0;
            end else if (m_own == NONE) begin
                if (p_pi && p_pd)
                    m_own = (m_last == OWN_I) ? OWN_D : OWN_I;
                else if (p_pd)
                    m_own = OWN_D;
                else if (p_pi)
                    m_own = OWN_I;
            end else if (p_mrdy) begin
                if (m_own == OWN_I) begin
                    m_ci = (m_ci == CMAX) ? CMAX : m_ci + 1;
                    if (q_i.size() > 0) void'(q_i.pop_front());
                end else begin
                    m_cd = (m_cd == CMAX) ? CMAX : m_cd + 1;
                    if (q_d.size() > 0) void'(q_d.pop_front());
                end
                m_last = m_own;
                m_own  = NONE;
            end

            chk("grant_I", 128'(grant_I), 128'(m_own == OWN_I));
            chk("grant_D", 128'(grant_D), 128'(m_own == OWN_D));
            chk("ready_I", 128'(ready_I), 128'((m_own == OWN_I) && mem_ready));
            chk("ready_D", 128'(ready_D), 128'((m_own == OWN_D) && mem_ready));
            chk("cnt_I", 128'(cnt_I), 128'(m_ci));
            chk("cnt_D", 128'(cnt_D), 128'(m_cd));
            if (m_own == NONE) begin
                chk("idle_mem_cmd", 128'({mem_read, mem_write}), 128'(0));
            end else if ((m_own == OWN_I && q_i.size() == 0) || (m_own == OWN_D && q_d.size() == 0)) begin
                vectors++;
                miscompares++;
                $display("FAIL grant_without_request: owner %0d has no queued request at %0t", m_own, $time);
            end else begin
                cur = (m_own == OWN_I) ? q_i[0] : q_d[0];
                chk("mem_addr", 128'(mem_addr), 128'(cur.addr));
                chk("mem_wdata", mem_wdata, cur.wdata);
                chk("mem_write", 128'(mem_write), 128'(cur.wr));
                chk("mem_read", 128'(mem_read), 128'(cur.rd && !cur.wr));
                if (mem_ready)
                    chk("rdata", (m_own == OWN_I) ? rdata_I : rdata_D, mem_rdata);
            end
        end
        p_pi   = read_I | write_I;
        p_pd   = read_D | write_D;
        p_mrdy = mem_ready;
    end

    // ---------------- randomized stimulus and memory responder -----------
    initial begin
        bit   act_i, act_d, s_ri, s_rd, s_gi, s_gd, rst_done;
        int   wait_cnt;
        req_t e;
        act_i = 1'b0; act_d = 1'b0; rst_done = 1'b0; wait_cnt = 2;
        read_I = 1'b0; write_I = 1'b0; addr_I = 28'd0; wdata_I = 128'd0;
        read_D = 1'b0; write_D = 1'b0; addr_D = 28'd0; wdata_D = 128'd0;
        mem_ready = 1'b0; mem_rdata = 128'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            s_ri = ready_I; s_rd = ready_D; s_gi = grant_I; s_gd = grant_D;
            if (!rst_done && cyc >= 1200 && s_gd && !mem_ready) begin
                // Reset in the middle of a D transaction; requests stay held.
                rst_done = 1'b1;
                #2 rst_n = 1'b0;
                #1;
                chk("async_rst_mem_write", 128'(mem_write), 128'(0));
                chk("async_rst_mem_read", 128'(mem_read), 128'(0));
                chk("async_rst_cnt_D", 128'(cnt_D), 128'(0));
                chk("async_rst_cnt_I", 128'(cnt_I), 128'(0));
                chk("async_rst_grant_D", 128'(grant_D), 128'(0));
                @(posedge clk);
                @(posedge clk);
                #1 rst_n = 1'b1;
                mem_ready = 1'b1;          // stray response while idle
                mem_rdata = rand128();
                wait_cnt  = 2;
                continue;
            end
            @(posedge clk);
            #1;
            if (act_i && s_ri) begin
                act_i = 1'b0; read_I = 1'b0; write_I = 1'b0;
            end else if (act_i && s_gi && $urandom_range(0, 3) == 0) begin
                addr_I = 28'($urandom()); wdata_I = rand128();
            end
            if (!act_i && $urandom_range(0, 3) != 0) begin
                e = rand_req(); q_i.push_back(e); act_i = 1'b1;
                read_I = e.rd; write_I = e.wr; addr_I = e.addr; wdata_I = e.wdata;
            end
            if (act_d && s_rd) begin
                act_d = 1'b0; read_D = 1'b0; write_D = 1'b0;
            end else if (act_d && s_gd && $urandom_range(0, 3) == 0) begin
                addr_D = 28'($urandom()); wdata_D = rand128();
            end
            if (!act_d && $urandom_range(0, 3) != 0) begin
                e = rand_req(); q_d.push_back(e); act_d = 1'b1;
                read_D = e.rd; write_D = e.wr; addr_D = e.addr; wdata_D = e.wdata;
            end
            if (mem_ready) begin
                mem_ready = 1'b0;
            end else if (mem_read || mem_write) begin
                if (wait_cnt == 0) begin
                    mem_ready = 1'b1; mem_rdata = rand128();
                end else begin
                    wait_cnt--;
                end
            end else begin
                wait_cnt = int'($urandom_range(0, 4));
                if ($urandom_range(0, 7) == 0) begin
                    mem_ready = 1'b1; mem_rdata = rand128();
                end
            end
        end
        repeat (5) @(posedge clk);
        chk("fixed_priority_sequence_done", 128'(fx_done), 128'(1));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // ---------------- directed fixed-priority scenario --------------------
    task automatic fx_txn(input logic exp_d);
        int n;
        n = 0;
        @(negedge clk);
        while (!(f_grant_I || f_grant_D) && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("fx_grant_D", 128'(f_grant_D), 128'(exp_d));
        chk("fx_grant_I", 128'(f_grant_I), 128'(!exp_d));
        chk("fx_mem_read", 128'(f_mem_read), 128'(1));
        @(posedge clk);
        #1 f_mem_ready = 1'b1;
        f_mem_rdata = {4{32'hA5A5A5A5}};
        @(negedge clk);
        chk("fx_ready_D", 128'(f_ready_D), 128'(exp_d));
        chk("fx_ready_I", 128'(f_ready_I), 128'(!exp_d));
        chk("fx_rdata", exp_d ? f_rdata_D : f_rdata_I, {4{32'hA5A5A5A5}});
        @(posedge clk);
        #1 f_mem_ready = 1'b0;
    endtask

    initial begin
        f_read_I = 1'b0; f_write_I = 1'b0; f_addr_I = 28'd0; f_wdata_I = 128'd0;
        f_read_D = 1'b0; f_write_D = 1'b0; f_addr_D = 28'd0; f_wdata_D = 128'd0;
        f_mem_ready = 1'b0; f_mem_rdata = 128'd0;
        #2;
        wait (rst_n === 1'b1);
        @(posedge clk);
        #1 f_read_I = 1'b1; f_read_D = 1'b1;
        f_addr_I = 28'h0000010; f_addr_D = 28'h0000020;
        for (int k = 0; k < 3; k++) begin
            fx_txn(1'b1);
            if (k == 2) f_read_D = 1'b0;
            @(negedge clk);
            chk("fx_cnt_D", 128'(f_cnt_D), 128'(k + 1));
            chk("fx_cnt_I_starved", 128'(f_cnt_I), 128'(0));
        end
        fx_txn(1'b0);
        f_read_I = 1'b0;
        @(negedge clk);
        chk("fx_cnt_I_served", 128'(f_cnt_I), 128'(1));
        chk("fx_cnt_D_final", 128'(f_cnt_D), 128'(3));
        fx_done = 1'b1;
    end

endmodule
